// File: rtl/csr_access_sequencer.sv
// Three-state (IDLE/READ/WRITE) read-modify-write sequencer between the CSR
// decoder and the CSR register file of the multicycle core.
module csr_access_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  csr_op,
   input  logic        csr_we,
   input  logic        csr_re,
   input  logic [11:0] csr_addr,
   input  logic [31:0] rs1_data,
   input  logic [4:0]  uimm,
   input  logic [1:0]  priv_mode,
   output logic [11:0] csrf_raddr,
   output logic        csrf_re,
   input  logic [31:0] csrf_rdata,
   input  logic        csrf_present,
   output logic [11:0] csrf_waddr,
   output logic [31:0] csrf_wdata,
   output logic        csrf_we,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_illegal
);

   localparam logic [3:0] CSR_OP_CSRRW  = 4'b0001;
   localparam logic [3:0] CSR_OP_CSRRS  = 4'b0010;
   localparam logic [3:0] CSR_OP_CSRRC  = 4'b0011;
   localparam logic [3:0] CSR_OP_CSRRWI = 4'b0101;
   localparam logic [3:0] CSR_OP_CSRRSI = 4'b0110;
   localparam logic [3:0] CSR_OP_CSRRCI = 4'b0111;
   localparam logic [3:0] CSR_OP_NA     = 4'b1000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2
   } state_t;

   state_t      r_state;
   logic [3:0]  r_op;
   logic        r_we;
   logic        r_re;
   logic [11:0] r_addr;
   logic [31:0] r_src;
   logic [1:0]  r_priv;

   logic        w_is_imm;
   logic [31:0] w_src_in;
   logic        w_pfault;
   logic        w_illegal;
   logic [31:0] w_new;

   assign w_is_imm = (csr_op == CSR_OP_CSRRWI) || (csr_op == CSR_OP_CSRRSI) ||
                     (csr_op == CSR_OP_CSRRCI);
   assign w_src_in = w_is_imm ? {27'b0, uimm} : rs1_data;

   // Ready is dropped combinationally while reset is held so nothing is accepted then.
   assign req_ready = (r_state == S_IDLE) && !reset;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values and simulation matches synthesis.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_op    <= CSR_OP_NA;
         r_we    <= 1'b0;
         r_re    <= 1'b0;
         r_addr  <= 12'h000;
         r_src   <= 32'h0;
         r_priv  <= 2'b00;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_op    <= csr_op;
                  r_we    <= csr_we;
                  r_re    <= csr_re;
                  r_addr  <= csr_addr;
                  r_src   <= w_src_in;
                  r_priv  <= priv_mode;
                  r_state <= S_READ;
               end
            end
            S_READ:  r_state <= S_WRITE;
            S_WRITE: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Faults knowable from the instruction alone, before the file is consulted.
   assign w_pfault  = (r_addr[9:8] > r_priv) ||
                      (r_we && (r_addr[11:10] == 2'b11)) ||
                      (r_op == CSR_OP_NA);
   assign w_illegal = w_pfault || !csrf_present;

   always_comb begin
      w_new = r_src;
      case (r_op)
         CSR_OP_CSRRW, CSR_OP_CSRRWI: w_new = r_src;
         CSR_OP_CSRRS, CSR_OP_CSRRSI: w_new = csrf_rdata | r_src;
         CSR_OP_CSRRC, CSR_OP_CSRRCI: w_new = csrf_rdata & ~r_src;
         default:                     w_new = r_src;
      endcase
   end

   // Strobes are gated by reset so a reset landing mid-request kills them in that cycle.
   // NOTE: every output gets a default before the case, so no latch is inferred.
   always_comb begin
      csrf_raddr  = 12'h000;
      csrf_waddr  = 12'h000;
      csrf_re     = 1'b0;
      csrf_wdata  = 32'h0;
      csrf_we     = 1'b0;
      rsp_valid   = 1'b0;
      rsp_illegal = 1'b0;
      rsp_rdata   = 32'h0;
      if (!reset) begin
         case (r_state)
            S_READ: begin
               csrf_raddr = r_addr;
               csrf_waddr = r_addr;
               csrf_re    = r_re && !w_pfault;
            end
            S_WRITE: begin
               csrf_raddr  = r_addr;
               csrf_waddr  = r_addr;
               csrf_wdata  = w_new;
               csrf_we     = r_we && !w_illegal;
               rsp_valid   = 1'b1;
               rsp_illegal = w_illegal;
               rsp_rdata   = (r_re && !w_illegal) ? csrf_rdata : 32'h0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_csr_access_sequencer.sv
// Directed bench for csr_access_sequencer: fixed request vectors with
// hand-computed file responses and expected strobes/results.
module tb_csr_access_sequencer;

   localparam logic [3:0] OP_RW  = 4'b0001;
   localparam logic [3:0] OP_RS  = 4'b0010;
   localparam logic [3:0] OP_RC  = 4'b0011;
   localparam logic [3:0] OP_RWI = 4'b0101;
   localparam logic [3:0] OP_RSI = 4'b0110;
   localparam logic [3:0] OP_NA  = 4'b1000;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  csr_op;
   logic        csr_we;
   logic        csr_re;
   logic [11:0] csr_addr;
   logic [31:0] rs1_data;
   logic [4:0]  uimm;
   logic [1:0]  priv_mode;
   logic [11:0] csrf_raddr;
   logic        csrf_re;
   logic [31:0] csrf_rdata;
   logic        csrf_present;
   logic [11:0] csrf_waddr;
   logic [31:0] csrf_wdata;
   logic        csrf_we;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_illegal;

   int n_cmp = 0;
   int n_bad = 0;

   csr_access_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .csr_op       (csr_op),
      .csr_we       (csr_we),
      .csr_re       (csr_re),
      .csr_addr     (csr_addr),
      .rs1_data     (rs1_data),
      .uimm         (uimm),
      .priv_mode    (priv_mode),
      .csrf_raddr   (csrf_raddr),
      .csrf_re      (csrf_re),
      .csrf_rdata   (csrf_rdata),
      .csrf_present (csrf_present),
      .csrf_waddr   (csrf_waddr),
      .csrf_wdata   (csrf_wdata),
      .csrf_we      (csrf_we),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_illegal  (rsp_illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Entered and left 1 time unit after a rising edge with the DUT idle.
   task automatic do_req(input string tag, input logic [3:0] op, input logic we, input logic re,
                         input logic [11:0] addr, input logic [31:0] rs1, input logic [4:0] imm,
                         input logic [1:0] priv, input logic [31:0] file, input logic pres,
                         input logic exp_re, input logic exp_we, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_rdata, input logic exp_ill);
      req_valid = 1'b1;
      csr_op = op; csr_we = we; csr_re = re; csr_addr = addr;
      rs1_data = rs1; uimm = imm; priv_mode = priv;
      @(negedge clk);
      check({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      // READ: scramble request fields and keep the file response invalid
      req_valid = 1'b0;
      csr_op = ~op; csr_we = ~we; csr_re = ~re; csr_addr = ~addr;
      rs1_data = ~rs1; uimm = ~imm; priv_mode = ~priv;
      csrf_rdata = 32'hBAD0_BAD0; csrf_present = 1'b0;
      @(negedge clk);
      check({tag, ".rd_re"},    32'(csrf_re),    32'(exp_re));
      check({tag, ".rd_raddr"}, 32'(csrf_raddr), 32'(addr));
      check({tag, ".rd_we"},    32'(csrf_we),    32'd0);
      check({tag, ".rd_rsp"},   32'(rsp_valid),  32'd0);
      check({tag, ".rd_ready"}, 32'(req_ready),  32'd0);
      @(posedge clk); #1;
      csrf_rdata = file; csrf_present = pres;
      @(negedge clk);
      check({tag, ".wr_rsp"},   32'(rsp_valid),   32'd1);
      check({tag, ".wr_ill"},   32'(rsp_illegal), 32'(exp_ill));
      check({tag, ".wr_rdata"}, rsp_rdata,        exp_rdata);
      check({tag, ".wr_we"},    32'(csrf_we),     32'(exp_we));
      check({tag, ".wr_re"},    32'(csrf_re),     32'd0);
      if (exp_we) begin
         check({tag, ".wr_waddr"}, 32'(csrf_waddr), 32'(addr));
         check({tag, ".wr_wdata"}, csrf_wdata,       exp_wdata);
      end
      @(posedge clk); #1;
      csrf_rdata = 32'h0; csrf_present = 1'b0;
   endtask

   initial begin
      logic [5:0] acc_mask;
      logic [5:0] rsp_mask;
      logic [5:0] we_mask;

      reset = 1'b1; req_valid = 1'b0;
      csr_op = OP_NA; csr_we = 1'b0; csr_re = 1'b0; csr_addr = 12'h0;
      rs1_data = 32'h0; uimm = 5'h0; priv_mode = 2'd3;
      csrf_rdata = 32'h0; csrf_present = 1'b0;

      // Reset state, with a request offered during reset that must be ignored
      repeat (3) @(posedge clk);
      #1 req_valid = 1'b1;
      @(negedge clk);
      check("rst.ready",  32'(req_ready),   32'd0);
      check("rst.re",     32'(csrf_re),     32'd0);
      check("rst.we",     32'(csrf_we),     32'd0);
      check("rst.rsp",    32'(rsp_valid),   32'd0);
      check("rst.ill",    32'(rsp_illegal), 32'd0);
      check("rst.rdata",  rsp_rdata,        32'd0);
      check("rst.wdata",  csrf_wdata,       32'd0);
      check("rst.raddr",  32'(csrf_raddr),  32'd0);
      @(posedge clk); #1;
      reset = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      check("rst.release_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;

      //     tag        op      we    re    addr     rs1           imm    pr  file          pres  xre   xwe   xwdata        xrdata        xill
      do_req("rs_nowr", OP_RS,  1'b0, 1'b1, 12'h300, 32'h0,        5'd0,  3, 32'h0000_1888, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0000_1888, 1'b0);
      do_req("rc_rmw",  OP_RC,  1'b1, 1'b1, 12'h304, 32'h0000_0080, 5'd0, 3, 32'h0000_0888, 1'b1, 1'b1, 1'b1, 32'h0000_0808, 32'h0000_0888, 1'b0);
      do_req("rwi_x0",  OP_RWI, 1'b1, 1'b0, 12'h340, 32'hDEAD_BEEF, 5'h1F, 3, 32'h0000_AAAA, 1'b1, 1'b0, 1'b1, 32'h0000_001F, 32'h0,        1'b0);
      do_req("rsi_set", OP_RSI, 1'b1, 1'b1, 12'h300, 32'hFFFF_FFFF, 5'h08, 3, 32'h0000_1800, 1'b1, 1'b1, 1'b1, 32'h0000_1808, 32'h0000_1800, 1'b0);
      do_req("s_ok",    OP_RS,  1'b1, 1'b1, 12'h100, 32'h0000_0002, 5'd0, 1, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0002, 32'h0,        1'b0);
      do_req("s_hyp",   OP_RS,  1'b0, 1'b1, 12'h200, 32'h0,        5'd0,  1, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1);
      do_req("u_priv",  OP_RS,  1'b0, 1'b1, 12'h300, 32'h0,        5'd0,  0, 32'h0000_1888, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1);
      do_req("ro_wr",   OP_RW,  1'b1, 1'b1, 12'hF14, 32'h0000_1234, 5'd0, 3, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1);
      do_req("ro_rd",   OP_RS,  1'b0, 1'b1, 12'hF14, 32'h0,        5'd0,  3, 32'h0000_0007, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0000_0007, 1'b0);
      do_req("op_na",   OP_NA,  1'b0, 1'b0, 12'h300, 32'h0,        5'd0,  3, 32'h0000_1888, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1);
      do_req("not_pres",OP_RSI, 1'b1, 1'b1, 12'h7FF, 32'h0,        5'd3,  3, 32'h0000_0005, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        1'b1);

      // Reset landing in READ: no write, no response, ready right after release
      req_valid = 1'b1; csr_op = OP_RW; csr_we = 1'b1; csr_re = 1'b1;
      csr_addr = 12'h340; rs1_data = 32'h0000_00AA; priv_mode = 2'd3;
      csrf_rdata = 32'h0000_0011; csrf_present = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      check("rst_rd.re",    32'(csrf_re),   32'd0);
      check("rst_rd.ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_rd.we",    32'(csrf_we),   32'd0);
      check("rst_rd.rsp",   32'(rsp_valid), 32'd0);
      check("rst_rd.ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;

      // Reset landing in WRITE: write and response suppressed in that cycle
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("rst_wr.we",  32'(csrf_we),   32'd0);
      check("rst_wr.rsp", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_wr.ready", 32'(req_ready), 32'd1);
      check("rst_wr.rsp2",  32'(rsp_valid), 32'd0);
      @(posedge clk); #1;

      // Back-to-back: req_valid held high across two requests
      acc_mask = '0; rsp_mask = '0; we_mask = '0;
      req_valid = 1'b1; csr_op = OP_RW; csr_we = 1'b1; csr_re = 1'b1;
      csr_addr = 12'h340; rs1_data = 32'h0000_0055; priv_mode = 2'd3;
      csrf_rdata = 32'h0000_0011; csrf_present = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         acc_mask[k] = req_ready & req_valid;
         rsp_mask[k] = rsp_valid;
         we_mask[k]  = csrf_we;
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      check("b2b.accepts", 32'(acc_mask), 32'(6'b001001));
      check("b2b.rsp",     32'(rsp_mask), 32'(6'b100100));
      check("b2b.we",      32'(we_mask),  32'(6'b100100));
      repeat (2) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/csr_access_sequencer.md
# csr_access_sequencer

Multicycle read-modify-write sequencer for CSR instructions in the kianv multicycle rv32ima core. It accepts one decoded CSR request from the control unit, which supplies the operation, write/read enables, CSR address and source operand. It then:

- reads the CSR file through its synchronous read port,
- checks privilege, read-only and presence rules,
- computes the new value and writes it back,
- returns the old value for rd, or flags an illegal-instruction exception.

It sits between the CSR decoder outputs and the CSR register file.

## Interface

Parameters: none. Widths are fixed by `riscv_defines.vh`.

Ports:

- clk  in  1  core clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  a CSR request is presented.
- req_ready  out  1  the sequencer can accept a request.
- csr_op  in  `CSR_OP_WIDTH`  operation, one of `CSR_OP_CSRRW/RS/RC/RWI/RSI/RCI/NA`.
- csr_we  in  1  instruction intends a CSR write (decoder CSRwe).
- csr_re  in  1  instruction intends a CSR read (decoder CSRre).
- csr_addr  in  12  CSR address, instr[31:20].
- rs1_data  in  32  rs1 register value, used by register-form ops.
- uimm  in  5  instr[19:15], used by immediate-form ops.
- priv_mode  in  2  current privilege level: 0 = U, 1 = S, 3 = M.
- csrf_raddr  out  12  CSR file read address.
- csrf_re  out  1  read strobe, for side-effecting reads.
- csrf_rdata  in  32  read data, valid the cycle after csrf_raddr.
- csrf_present  in  1  address is implemented; same timing as csrf_rdata.
- csrf_waddr  out  12  CSR file write address.
- csrf_wdata  out  32  CSR file write data.
- csrf_we  out  1  write strobe, single cycle.
- rsp_valid  out  1  single-cycle completion pulse.
- rsp_rdata  out  32  old CSR value destined for rd.
- rsp_illegal  out  1  raise an illegal-instruction trap; qualified by rsp_valid.

## Operation

States are IDLE, READ and WRITE.

- **IDLE**
  - req_ready = 1.
  - When req_valid = 1, capture csr_op, csr_we, csr_re, csr_addr, the source operand and priv_mode, then go to READ.
  - Source operand: rs1_data for RW/RS/RC; {27'b0, uimm} for RWI/RSI/RCI.
- **READ**
  - Drive csrf_raddr = captured address.
  - Compute pre-read fault `pfault` from the captured fields. pfault is set if any of:
    - addr[9:8] > priv_mode;
    - csr_we = 1 and addr[11:10] = 2'b11;
    - csr_op = `CSR_OP_NA`.
  - csrf_re = csr_re_q & ~pfault.
  - Unconditionally go to WRITE.
- **WRITE**
  - illegal = pfault | ~csrf_present.
  - new value:
    - RW/RWI: src.
    - RS/RSI: csrf_rdata | src.
    - RC/RCI: csrf_rdata & ~src.
  - Write: csrf_we = csr_we_q & ~illegal, with csrf_waddr = captured address and csrf_wdata = new value.
  - Response: rsp_valid = 1 and rsp_illegal = illegal.
  - rsp_rdata = (csr_re_q & ~illegal) ? csrf_rdata : 0.
  - Return to IDLE.

Rules:

- At most one csrf_re and one csrf_we per request.
- No write ever occurs on an illegal request.
- csrf_we and rsp_valid are asserted in the same cycle.
- All arithmetic is 32-bit bitwise; there is no carry.
- csrf_raddr/csrf_waddr hold the captured address from READ through WRITE. In IDLE they are don't-care (drive 0).

## Timing

Reset state:

- state = IDLE.
- req_ready = 0 while reset is high; 1 in the first cycle after reset is released.
- csrf_re, csrf_we, rsp_valid and rsp_illegal are 0; rsp_rdata, csrf_wdata and csrf_raddr are 0.

Request timing:

- Accept on cycle N (IDLE, valid & ready).
- Read strobe on N+1.
- Write and response on N+2.
- Next accept is possible on N+3; throughput is one request per 3 cycles.
- req_ready is low during READ and WRITE. req_valid seen there is ignored, so the requester must hold it.

Boundary conditions:

- Reset asserted during READ or WRITE: the cycle it is sampled returns to IDLE. The CSR write and rsp_valid are suppressed in that cycle.
- Request fields may change after acceptance; only the captured copies are used.
- csrf_present is sampled only in WRITE, not in READ.

## Test plan

- **csrrs, no write.** priv=M, csrrs x5, mstatus (0x300), rs1=x0 (csr_we=0, csr_re=1), file holds 0x00001888. Expect csrf_re on N+1; on N+2 rsp_rdata=0x00001888, csrf_we=0, rsp_illegal=0.
- **csrrc read-modify-write.** csrrc, mie (0x304), rs1_data=0x00000080, file 0x00000888. Expect on N+2 csrf_we=1, csrf_wdata=0x00000808, rsp_rdata=0x00000888.
- **csrrwi, rd=x0.** csr_re=0, uimm=5'h1F, addr 0x340. Expect csrf_re=0; csrf_wdata=0x0000001F; rsp_rdata=0.
- **Privilege and read-only faults.**
  - priv=U, csrrs, addr 0x300: csrf_re=0, csrf_we=0, rsp_illegal=1, rsp_rdata=0.
  - priv=M, csrrw to 0xF14 (mhartid, read-only): rsp_illegal=1, no write.
- **Not present, then reset.**
  - csrf_present=0 for addr 0x7FF, csrrsi uimm=3: rsp_illegal=1, csrf_we=0.
  - Separately, assert reset during READ: no csrf_we or rsp_valid occurs, req_ready=1 on the first cycle after reset is released.
- **Back-to-back requests.** Hold req_valid for two requests. Expect accepts at N and N+3 and rsp_valid at N+2 and N+5, with no overlap of csrf_we.
